rgb565_de_rx: RTL and testbench
===============================

# rgb565_de_rx

Receive side of the parallel RGB565 DE-mode video link: samples an externally driven `pclk`/`de`/`rgb565` bus in the fabric clock domain, locks to frame timing, and emits a pixel stream tagged with x/y coordinates and a linear framebuffer address. It sits between the board's parallel video input pins and a framebuffer writer. It also checks received geometry against the expected 480x272 panel timing.

## Interface
Parameters:
- `H_ACTIVE`, 480, expected active pixels per line
- `V_ACTIVE`, 272, expected active lines per frame
- `VBLANK_MIN`, 1024, consecutive de-low pclk periods that mark vertical blanking
- `PCLK_TIMEOUT`, 64, fabric clocks without a pclk edge before link is declared lost

Ports:
- `clk`  in  1  fabric clock, 50 MHz, ≥4× pclk
- `rst`  in  1  asynchronous, active-high reset
- `pclk`  in  1  external pixel clock, asynchronous to `clk`
- `de`  in  1  data enable, launched on pclk rising edge
- `rgb565`  in  16  pixel data {r[4:0], g[5:0], b[4:0]}, launched on pclk rising edge
- `pix_valid`  out  1  one-clk strobe per received active pixel
- `pix_data`  out  16  pixel value, valid with `pix_valid`
- `pix_x`  out  10  column of `pix_data`
- `pix_y`  out  9  row of `pix_data`
- `pix_addr`  out  17  `pix_y*H_ACTIVE + pix_x`
- `sof`  out  1  asserted with first `pix_valid` of a frame
- `eol`  out  1  one-clk strobe after last pixel of a line
- `link_up`  out  1  pclk toggling and frame lock acquired
- `err_len`  out  1  sticky: a line length ≠ `H_ACTIVE`
- `err_lines`  out  1  sticky: frame line count ≠ `V_ACTIVE`
- `last_width`  out  10  pixel count of most recent completed line
- `last_height`  out  9  line count of most recent completed frame

## Operation
- `pclk`, `de`, `rgb565` each pass a 2-flop synchronizer; a third stage on `pclk` gives edge detect.
- Sampling happens on the synchronized pclk falling edge (mid-bit, since the transmitter launches on rising edges); `de`/`rgb565` taken from the same synchronizer stage.
- `blank_cnt` (11b, saturating) counts sampled de-low periods; cleared on any de-high sample.
- `to_cnt` counts clk cycles since the last pclk edge; reaching `PCLK_TIMEOUT` → state NO_SIGNAL.
- FSM:
  - NO_SIGNAL: `link_up`=0; on any pclk edge → WAIT_VBLANK.
  - WAIT_VBLANK: `link_up`=0; `blank_cnt` reaches `VBLANK_MIN` → HBLANK, y=0, arm sof.
  - HBLANK: `link_up`=1; de-high sample → ACTIVE, x=0, emit pixel; `blank_cnt` reaching `VBLANK_MIN` closes the frame: `last_height`←y, `err_lines` set if y≠`V_ACTIVE`, y←0, re-arm sof.
  - ACTIVE: each de-high sample emits pixel, x++; de-low sample → HBLANK, `eol`, `last_width`←x, `err_len` set if x≠`H_ACTIVE`, y++.
- `pix_addr` kept incrementally (+1 per pixel; line base +`H_ACTIVE` per eol); no multiplier.
- x saturates at 1023, y at 511; no pix_valid while x ≥ `H_ACTIVE` or y ≥ `V_ACTIVE` (overflow pixels dropped, still counted for `last_width`).
- Errors sticky until `rst`.

## Timing
- Reset values: all outputs 0; state NO_SIGNAL; counters 0.
- Latency: `pix_valid` 4 clk after the pclk falling edge at the pin (2 sync + edge + register).
- `pix_valid` width exactly 1 clk; never on consecutive clocks when `clk` ≥ 4× pclk.
- `eol` one clk, issued on the clk where the de-low sample is taken; never coincident with `pix_valid`.
- `sof` coincident with `pix_valid` only.
- Timeout and frame close on the same clk: timeout wins (→ NO_SIGNAL, no height update).
- `rst` mid-line: immediate return to NO_SIGNAL; first frame after reset is never emitted partially.

## Structure
- Shared package/header: panel timing constants (480, 272, 256 hblank, 45 vblank) shared with the LCD transmitter top, RGB565 field widths.
- One sub-module: `sync_edge` (2-flop synchronizer + edge detect), instantiated for pclk and reused for de and data bits.

## Test plan
- Reset held, bus toggling → all outputs 0; release, 2 full 480x272 frames at 8.33 MHz → first frame silent, second frame 130560 `pix_valid`, `sof` once, 272 `eol`, `last_width`=480, `last_height`=272.
- Pixel (x=159,y=10)=0xF800 → `pix_addr`=4959, `pix_data`=0xF800, `pix_x`=159, `pix_y`=10.
- One line of 479 pixels → `err_len`=1, `last_width`=479, stays 1 after later good lines.
- Frame of 271 lines → `err_lines`=1, `last_height`=271.
- pclk stopped mid-line for 100 clk → `link_up` 0 within 64+3 clk; restart → relock only after next vblank.
- `rst` pulsed mid-line → outputs 0 asynchronously, no `pix_valid` until full vblank seen.

Source files
------------

// File: rtl/rgb565_de_rx_pkg.sv
// Shared constants for the parallel RGB565 DE-mode video link.
// Panel timing (480x272 active, 256 pclk hblank, 45 lines vblank) is shared
// with the LCD transmitter top; field widths describe the RGB565 word and
// the coordinate/address outputs of the receiver.
package rgb565_de_rx_pkg;

  localparam int PANEL_H_ACTIVE = 480;
  localparam int PANEL_V_ACTIVE = 272;
  localparam int PANEL_H_BLANK  = 256;
  localparam int PANEL_V_BLANK  = 45;

  localparam int RGB_R_W = 5;
  localparam int RGB_G_W = 6;
  localparam int RGB_B_W = 5;
  localparam int PIX_W   = RGB_R_W + RGB_G_W + RGB_B_W;

  localparam int X_W     = 10;
  localparam int Y_W     = 9;
  localparam int ADDR_W  = 17;
  localparam int BLANK_W = 11;

  typedef enum logic [1:0] {
    ST_NO_SIGNAL,
    ST_WAIT_VBLANK,
    ST_HBLANK,
    ST_ACTIVE
  } rx_state_e;

endpackage

// File: rtl/rgb565_de_rx_sync.sv
// sync_edge: 2-flop synchronizer for an async bus plus a dedicated edge
// input that gets a third stage for rising/falling edge detection.
// Ports:
//   clk_i, rst_i     fabric clock, async active-high reset
//   edge_i           async strobe-like input (pclk) to edge-detect
//   d_i[W-1:0]       async data bits (de, rgb565) synchronized alongside
//   q_o[W-1:0]       d_i after 2 stages, aligned with rise_o/fall_o
//   rise_o, fall_o   one-clk edge pulses of edge_i (2nd vs 3rd stage)
module sync_edge #(
  parameter int W = 1
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         edge_i,
  input  logic [W-1:0] d_i,
  output logic [W-1:0] q_o,
  output logic         rise_o,
  output logic         fall_o
);

  logic [W-1:0] d1_q, d2_q;
  logic         e1_q, e2_q, e3_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      d1_q <= '0;
      d2_q <= '0;
      e1_q <= 1'b0;
      e2_q <= 1'b0;
      e3_q <= 1'b0;
    end else begin
      d1_q <= d_i;
      d2_q <= d1_q;
      e1_q <= edge_i;
      e2_q <= e1_q;
      e3_q <= e2_q;
    end
  end

  assign q_o    = d2_q;
  assign rise_o =  e2_q & ~e3_q;
  assign fall_o = ~e2_q &  e3_q;

endmodule

// File: rtl/rgb565_de_rx.sv
// rgb565_de_rx: receive side of the parallel RGB565 DE-mode link.
// Oversamples pclk/de/rgb565 in the clk domain, samples on pclk falling
// edges, locks to frame timing via long de-low runs and emits a pixel
// stream with x/y and linear framebuffer address; checks geometry.
// Ports:
//   clk, rst                 fabric clock, async active-high reset
//   pclk, de, rgb565         external video bus (async to clk)
//   pix_valid/pix_data/pix_x/pix_y/pix_addr   pixel stream
//   sof, eol                 start-of-frame / end-of-line strobes
//   link_up                  pclk alive and frame-locked
//   err_len, err_lines       sticky geometry errors
//   last_width, last_height  geometry of last completed line/frame
module rgb565_de_rx
  import rgb565_de_rx_pkg::*;
#(
  parameter int H_ACTIVE     = PANEL_H_ACTIVE,
  parameter int V_ACTIVE     = PANEL_V_ACTIVE,
  parameter int VBLANK_MIN   = 1024,
  parameter int PCLK_TIMEOUT = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              pclk,
  input  logic              de,
  input  logic [PIX_W-1:0]  rgb565,
  output logic              pix_valid,
  output logic [PIX_W-1:0]  pix_data,
  output logic [X_W-1:0]    pix_x,
  output logic [Y_W-1:0]    pix_y,
  output logic [ADDR_W-1:0] pix_addr,
  output logic              sof,
  output logic              eol,
  output logic              link_up,
  output logic              err_len,
  output logic              err_lines,
  output logic [X_W-1:0]    last_width,
  output logic [Y_W-1:0]    last_height
);

  localparam int TO_W = $clog2(PCLK_TIMEOUT + 1);

  // synchronizer + edge detect; de/data share the pclk stage depth
  logic [PIX_W:0] bus_s;
  logic           p_rise, p_fall, p_edge;

  sync_edge #(.W(PIX_W + 1)) u_sync (
    .clk_i  (clk),
    .rst_i  (rst),
    .edge_i (pclk),
    .d_i    ({de, rgb565}),
    .q_o    (bus_s),
    .rise_o (p_rise),
    .fall_o (p_fall)
  );

  assign p_edge = p_rise | p_fall;

  // sample register: de/data captured on the clk the falling edge is seen
  logic             smp_q, de_q;
  logic [PIX_W-1:0] data_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      smp_q  <= 1'b0;
      de_q   <= 1'b0;
      data_q <= '0;
    end else begin
      smp_q <= p_fall;
      if (p_fall) begin
        de_q   <= bus_s[PIX_W];
        data_q <= bus_s[PIX_W-1:0];
      end
    end
  end

  rx_state_e         state_q, state_d;
  logic [X_W-1:0]    x_q, x_d;
  logic [Y_W-1:0]    y_q, y_d;
  logic [ADDR_W-1:0] addr_q, addr_d, base_q, base_d;
  logic              sof_arm_q, sof_arm_d;
  logic [BLANK_W-1:0] blank_q, blank_d;
  logic [TO_W-1:0]   to_q, to_d;
  logic              pv_q, pv_d, sof_q, sof_d, eol_q, eol_d;
  logic [PIX_W-1:0]  pdata_q, pdata_d;
  logic [X_W-1:0]    px_q, px_d, lw_q, lw_d;
  logic [Y_W-1:0]    py_q, py_d, lh_q, lh_d;
  logic [ADDR_W-1:0] paddr_q, paddr_d;
  logic              err_len_q, err_len_d, err_lines_q, err_lines_d;

  logic              timeout, vb_hit, emit;
  logic [X_W-1:0]    emit_x;
  logic [ADDR_W-1:0] emit_addr;

  always_comb begin
    state_d     = state_q;
    x_d         = x_q;
    y_d         = y_q;
    addr_d      = addr_q;
    base_d      = base_q;
    sof_arm_d   = sof_arm_q;
    blank_d     = blank_q;
    to_d        = to_q;
    pv_d        = 1'b0;
    sof_d       = 1'b0;
    eol_d       = 1'b0;
    pdata_d     = pdata_q;
    px_d        = px_q;
    py_d        = py_q;
    paddr_d     = paddr_q;
    lw_d        = lw_q;
    lh_d        = lh_q;
    err_len_d   = err_len_q;
    err_lines_d = err_lines_q;
    emit        = 1'b0;
    emit_x      = x_q;
    emit_addr   = addr_q;

    // pclk watchdog, saturating at the timeout value
    if (p_edge)
      to_d = '0;
    else if (to_q != TO_W'(PCLK_TIMEOUT))
      to_d = to_q + 1'b1;
    timeout = !p_edge && (to_d == TO_W'(PCLK_TIMEOUT));

    // blank run length; vb_hit fires once, on the sample that reaches the min
    vb_hit = smp_q && !de_q && (blank_q == BLANK_W'(VBLANK_MIN - 1));
    if (smp_q) begin
      if (de_q)
        blank_d = '0;
      else if (blank_q != '1)
        blank_d = blank_q + 1'b1;
    end

    case (state_q)
      ST_NO_SIGNAL: begin
        // stale blank history must not count toward the relock vblank
        blank_d = '0;
        if (p_edge) state_d = ST_WAIT_VBLANK;
      end
      ST_WAIT_VBLANK: begin
        if (vb_hit) begin
          state_d   = ST_HBLANK;
          y_d       = '0;
          base_d    = '0;
          sof_arm_d = 1'b1;
        end
      end
      ST_HBLANK: begin
        if (smp_q && de_q) begin
          state_d   = ST_ACTIVE;
          emit      = 1'b1;
          emit_x    = '0;
          emit_addr = base_q;
          x_d       = X_W'(1);
          addr_d    = base_q + 1'b1;
        end else if (vb_hit) begin
          lh_d      = y_q;
          if (y_q != Y_W'(V_ACTIVE)) err_lines_d = 1'b1;
          y_d       = '0;
          base_d    = '0;
          sof_arm_d = 1'b1;
        end
      end
      ST_ACTIVE: begin
        if (smp_q) begin
          if (de_q) begin
            emit   = 1'b1;
            x_d    = (x_q == '1) ? x_q : x_q + 1'b1;
            addr_d = addr_q + 1'b1;
          end else begin
            state_d = ST_HBLANK;
            eol_d   = 1'b1;
            lw_d    = x_q;
            if (x_q != X_W'(H_ACTIVE)) err_len_d = 1'b1;
            y_d     = (y_q == '1) ? y_q : y_q + 1'b1;
            // base only advances inside the framebuffer so it cannot wrap
            if (y_q < Y_W'(V_ACTIVE)) base_d = base_q + ADDR_W'(H_ACTIVE);
          end
        end
      end
      default: state_d = ST_NO_SIGNAL;
    endcase

    // out-of-window pixels are counted in x but never emitted
    if (emit && (emit_x < X_W'(H_ACTIVE)) && (y_q < Y_W'(V_ACTIVE))) begin
      pv_d      = 1'b1;
      sof_d     = sof_arm_q;
      sof_arm_d = 1'b0;
      pdata_d   = data_q;
      px_d      = emit_x;
      py_d      = y_q;
      paddr_d   = emit_addr;
    end

    // losing pclk overrides anything decided this clk
    if (timeout && (state_q != ST_NO_SIGNAL)) begin
      state_d     = ST_NO_SIGNAL;
      pv_d        = 1'b0;
      sof_d       = 1'b0;
      eol_d       = 1'b0;
      lh_d        = lh_q;
      err_lines_d = err_lines_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_NO_SIGNAL;
      x_q         <= '0;
      y_q         <= '0;
      addr_q      <= '0;
      base_q      <= '0;
      sof_arm_q   <= 1'b0;
      blank_q     <= '0;
      to_q        <= '0;
      pv_q        <= 1'b0;
      sof_q       <= 1'b0;
      eol_q       <= 1'b0;
      pdata_q     <= '0;
      px_q        <= '0;
      py_q        <= '0;
      paddr_q     <= '0;
      lw_q        <= '0;
      lh_q        <= '0;
      err_len_q   <= 1'b0;
      err_lines_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      x_q         <= x_d;
      y_q         <= y_d;
      addr_q      <= addr_d;
      base_q      <= base_d;
      sof_arm_q   <= sof_arm_d;
      blank_q     <= blank_d;
      to_q        <= to_d;
      pv_q        <= pv_d;
      sof_q       <= sof_d;
      eol_q       <= eol_d;
      pdata_q     <= pdata_d;
      px_q        <= px_d;
      py_q        <= py_d;
      paddr_q     <= paddr_d;
      lw_q        <= lw_d;
      lh_q        <= lh_d;
      err_len_q   <= err_len_d;
      err_lines_q <= err_lines_d;
    end
  end

  assign pix_valid   = pv_q;
  assign pix_data    = pdata_q;
  assign pix_x       = px_q;
  assign pix_y       = py_q;
  assign pix_addr    = paddr_q;
  assign sof         = sof_q;
  assign eol         = eol_q;
  assign link_up     = (state_q == ST_HBLANK) || (state_q == ST_ACTIVE);
  assign err_len     = err_len_q;
  assign err_lines   = err_lines_q;
  assign last_width  = lw_q;
  assign last_height = lh_q;

endmodule

// File: tb/tb_rgb565_de_rx.sv
// Bench for rgb565_de_rx on a scaled-down 16x6 panel so whole frames stay
// short. A line/frame-level reference model predicts the pixel stream,
// strobes, geometry and error flags from the driven video.
module tb_rgb565_de_rx;

  localparam int H   = 16;
  localparam int V   = 6;
  localparam int VBM = 40;
  localparam int TO  = 64;
  localparam int HB  = 8;
  localparam int VBL = 4;
  localparam int PH  = 61;   // pclk half period; clk period is 20

  logic        clk = 1'b0, rst = 1'b1, pclk = 1'b0, de = 1'b0;
  logic [15:0] rgb565 = '0;
  logic        pix_valid, sof, eol, link_up, err_len, err_lines;
  logic [15:0] pix_data;
  logic [9:0]  pix_x, last_width;
  logic [8:0]  pix_y, last_height;
  logic [16:0] pix_addr;

  always #10 clk = ~clk;

  rgb565_de_rx #(.H_ACTIVE(H), .V_ACTIVE(V), .VBLANK_MIN(VBM), .PCLK_TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .pclk(pclk), .de(de), .rgb565(rgb565),
    .pix_valid(pix_valid), .pix_data(pix_data), .pix_x(pix_x), .pix_y(pix_y),
    .pix_addr(pix_addr), .sof(sof), .eol(eol), .link_up(link_up),
    .err_len(err_len), .err_lines(err_lines),
    .last_width(last_width), .last_height(last_height)
  );

  int n_chk = 0, n_fail = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // reference model state
  typedef struct { logic [15:0] d; int x; int y; int a; bit s; } pix_t;
  pix_t exp_q[$];
  bit   locked, prev_de, sof_pend, err_len_m, err_lines_m;
  int   lowrun, mx, my, lw_m, lh_m;
  int   eol_exp = 0, sof_exp = 0, eol_seen = 0, sof_seen = 0, pix_seen = 0;
  bit   pv_prev = 0;

  task automatic unlock_model();
    locked = 0; lowrun = 0; prev_de = 0; sof_pend = 0; mx = 0; my = 0;
  endtask

  task automatic reset_model();
    unlock_model();
    lw_m = 0; lh_m = 0; err_len_m = 0; err_lines_m = 0;
    exp_q.delete();
  endtask

  task automatic drive_period(input logic d, input logic [15:0] v);
    pix_t e;
    pclk = 1'b1; de = d; rgb565 = v;
    if (d) begin
      if (!prev_de) mx = 0;
      if (locked && mx < H && my < V) begin
        e.d = v; e.x = mx; e.y = my; e.a = my * H + mx; e.s = sof_pend;
        if (sof_pend) sof_exp++;
        sof_pend = 0;
        exp_q.push_back(e);
      end
      if (mx < 1023) mx++;
      lowrun = 0;
    end else begin
      if (prev_de && locked) begin
        eol_exp++;
        lw_m = mx;
        if (mx != H) err_len_m = 1;
        if (my < 511) my++;
      end
      if (lowrun < 2047) lowrun++;
      if (lowrun == VBM) begin
        if (locked) begin
          lh_m = my;
          if (my != V) err_lines_m = 1;
        end
        locked = 1; my = 0; sof_pend = 1;
      end
    end
    prev_de = d;
    #PH pclk = 1'b0;
    #PH;
  endtask

  task automatic drive_px(input int n);
    for (int i = 0; i < n; i++) drive_period(1'b1, 16'($urandom));
  endtask

  task automatic drive_lo(input int n);
    for (int i = 0; i < n; i++) drive_period(1'b0, 16'($urandom));
  endtask

  task automatic drive_line(input int len);
    drive_px(len);
    drive_lo(HB);
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic chk_state(input string tag);
    @(negedge clk);
    chk({tag, "_qempty"},    exp_q.size(), 0);
    chk({tag, "_eol_cnt"},   eol_seen, eol_exp);
    chk({tag, "_sof_cnt"},   sof_seen, sof_exp);
    chk({tag, "_lwidth"},    last_width, lw_m);
    chk({tag, "_lheight"},   last_height, lh_m);
    chk({tag, "_err_len"},   err_len, err_len_m);
    chk({tag, "_err_lines"}, err_lines, err_lines_m);
    chk({tag, "_link_up"},   link_up, locked);
  endtask

  task automatic drive_frame(input int nlines, input int bad_line, input int bad_len);
    for (int l = 0; l < nlines; l++) begin
      drive_line((l == bad_line) ? bad_len : H);
      if (l == bad_line) chk_state("bad_line");
    end
    drive_lo(VBL * (H + HB));
  endtask

  // output monitor / scoreboard
  always @(negedge clk) begin
    pix_t e;
    if (pix_valid) begin
      pix_seen++;
      chk("pv_gap", pv_prev, 0);
      chk("pix_expected", exp_q.size() != 0, 1);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        chk("pix_data", pix_data, e.d);
        chk("pix_x",    pix_x,    e.x);
        chk("pix_y",    pix_y,    e.y);
        chk("pix_addr", pix_addr, e.a);
        chk("pix_sof",  sof,      e.s);
      end
    end
    if (sof) begin
      sof_seen++;
      chk("sof_with_pv", pix_valid, 1);
    end
    if (eol) begin
      eol_seen++;
      chk("eol_excl_pv", pix_valid, 0);
    end
    pv_prev = pix_valid;
  end

  initial begin
    #1200000;
    $display("FAIL watchdog time limit reached checks=%0d", n_chk);
    $fatal(1, "watchdog");
  end

  int p0;

  initial begin
    reset_model();
    // reset held while the bus toggles
    for (int i = 0; i < 20; i++) begin
      pclk = 1'b1; de = 1'($urandom_range(0, 1)); rgb565 = 16'($urandom);
      #PH pclk = 1'b0;
      #PH;
      if (i % 5 == 4) begin
        @(negedge clk);
        chk("rst_outs", |{pix_valid, pix_data, pix_x, pix_y, pix_addr, sof, eol,
                          link_up, err_len, err_lines, last_width, last_height}, 0);
      end
    end
    wait_clk(2);
    #3 rst = 1'b0;

    drive_frame(V, -1, H);                 // partial lock: silent
    chk_state("f1");
    chk("f1_pix", pix_seen, 0);
    p0 = pix_seen;
    drive_frame(V, -1, H);
    chk_state("f2");
    chk("f2_pix", pix_seen - p0, H * V);

    drive_frame(V, 2, H - 1);              // short line
    chk_state("f3");
    drive_frame(V - 1, -1, H);             // short frame
    chk_state("f4");
    drive_frame(V + 1, 1, H + 2);          // long line, extra line dropped
    chk_state("f5");
    drive_frame(V, $urandom_range(0, V - 1), $urandom_range(10, 20));
    chk_state("f6");

    // pclk stops mid-line
    drive_line(H); drive_line(H); drive_px(5);
    wait_clk(40);
    chk("to_link_hold", link_up, 1);
    wait_clk(27);
    chk("to_link_lost", link_up, 0);
    wait_clk(33);
    unlock_model();
    p0 = pix_seen;
    drive_px(H - 5); drive_lo(HB);
    for (int l = 3; l < V; l++) drive_line(H);
    wait_clk(1);
    chk("relock_wait", link_up, 0);
    drive_lo(VBL * (H + HB));
    chk("restart_pix", pix_seen - p0, 0);
    chk_state("restart");
    p0 = pix_seen;
    drive_frame(V, -1, H);
    chk("relock_pix", pix_seen - p0, H * V);
    chk_state("relock");

    // async reset mid-line
    drive_line(H); drive_line(H); drive_line(H); drive_px(7);
    wait_clk(10);
    #3 rst = 1'b1;
    #1;
    chk("arst_outs", |{pix_valid, pix_data, pix_x, pix_y, pix_addr, sof, eol,
                       link_up, err_len, err_lines, last_width, last_height}, 0);
    chk("arst_err_len", err_len, 0);
    reset_model();
    wait_clk(3);
    #3 rst = 1'b0;
    p0 = pix_seen;
    drive_px(H - 7); drive_lo(HB);
    for (int l = 4; l < V; l++) drive_line(H);
    drive_lo(VBL * (H + HB));
    chk("post_rst_pix", pix_seen - p0, 0);
    chk_state("post_rst");
    p0 = pix_seen;
    drive_frame(V, -1, H);
    chk("post_rst_frame_pix", pix_seen - p0, H * V);
    chk_state("post_rst_frame");

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
